tx_result_sender: RTL and testbench
===================================

# tx_result_sender

Response serializer between the match engine and `async_transmitter`. Captures one match report (found flag, 32-bit byte offset, match length) or a loopback test request and emits it as a byte frame over the `TxD_start`/`TxD_busy` handshake, one byte at a time. Sits directly upstream of `async_transmitter` inside `top_md5`. Its output is what the host (or the testbench's `async_receiver`) reads back.

## Interface
Parameters:
- `TEST_COUNT`, 4: first byte of the test frame; the frame counts down to 1. Legal range 1..255.

Ports:
- `clk` in 1: single clock, 100 MHz in `top_md5`.
- `reset` in 1: synchronous, active-high.
- `report_start` in 1: one-cycle request to send a match frame; sampled only in IDLE.
- `report_found` in 1: match flag, captured with `report_start`.
- `report_pos` in 32: byte offset of the match in the text stream, captured with `report_start`.
- `report_len` in 8: matched string length, captured with `report_start`.
- `test_start` in 1: one-cycle request to send the test frame (host cmd 0x04); sampled only in IDLE.
- `sender_busy` out 1: high from the accept cycle until the frame's last handshake completes.
- `txd_start` out 1: one-cycle strobe to `async_transmitter`.
- `txd_data` out 8: byte to transmit; valid when `txd_start` is high, 0x00 otherwise.
- `txd_busy` in 1: `async_transmitter` busy.

## Operation
- Frame formats:
  - Match found: 0x01, pos[31:24], pos[23:16], pos[15:8], pos[7:0], len. That is 6 bytes, with the position big-endian.
  - No match: 0x00. That is 1 byte; `report_pos` and `report_len` are ignored.
  - Test frame: TEST_COUNT, TEST_COUNT-1, …, 1. That is TEST_COUNT bytes.
- On accept, latch the inputs into a 48-bit shift register and load a 3-bit byte counter (match frames) or an 8-bit down-counter (test frame).
- States:
  - IDLE: transitions as follows.
    - `report_start` → LOAD.
    - Else `test_start` → LOAD.
    - `report_start` wins when both are high; the simultaneous `test_start` is dropped, not queued.
  - LOAD: wait for `txd_busy==0`, then → STROBE.
  - STROBE: `txd_start=1` and `txd_data` = current byte for exactly one cycle → HOLD.
  - HOLD: one dead cycle, covering the one-cycle lag of `txd_busy` after a strobe → WAIT.
  - WAIT: when `txd_busy==0`:
    - If bytes remain, shift or decrement → STROBE.
    - Otherwise → IDLE.
- Requests arriving outside IDLE are ignored.
- `report_*` inputs are not re-sampled mid-frame.

## Timing
- Reset values:
  - `txd_start=0`, `txd_data=0x00`, `sender_busy=0`.
  - State IDLE, shift register 0, counters 0.
- Reset mid-frame: the block returns to IDLE on the next edge and the rest of the frame is discarded. A byte already handed to the transmitter still completes; that is outside this block.
- Latency with `txd_busy` low:
  - Request sampled at edge N.
  - `sender_busy` high after N.
  - First `txd_start` high in cycle N+2 (LOAD at N+1).
- Inter-byte gap: the next STROBE comes one cycle after `txd_busy` falls. At 12 Mbaud / 100 MHz this gives about 84 cycles per byte.
- `sender_busy` falls on the edge that returns to IDLE. A new request can be accepted on the following edge.
- `txd_busy` already high when entering LOAD: the block waits; no strobe is issued while `txd_busy` is high.
- Counter widths:
  - Test down-counter is 8 bits and stops at 1; there is no wrap to 0.
  - Match byte index counts 0..5.

## Structure
- Shared package `munch_pkg` holds:
  - State encoding constants (IDLE, LOAD, STROBE, HOLD, WAIT).
  - `RESP_FOUND = 8'h01` and `RESP_NOT_FOUND = 8'h00`.
  - `CMD_TEST = 8'h04`.
  - These are reused by the command parser.
- A single module; no sub-module. The byte-select logic is a shift register, not a mux tree.

## Test plan
- Match report: `report_found=1`, `pos=0x0001_27D3`, `len=9`, with `async_receiver` looped back → bytes 0x01, 0x00, 0x01, 0x27, 0xD3, 0x09 in order. Exactly 6 `txd_start` pulses, each one cycle wide.
- No match: `report_found=0`, `pos=0xFFFF_FFFF` → single byte 0x00. `sender_busy` low within 1 cycle of `txd_busy` falling.
- Test frame: `test_start` with TEST_COUNT=4 → 4, 3, 2, 1. The receiver loop terminates on the byte value 1.
- Collision: `report_start` and `test_start` in the same cycle (found, pos=0x10, len=3) → match frame only. A second `test_start` pulsed mid-frame produces no extra bytes.
- Backpressure: hold `txd_busy=1` for 50 cycles before the request → no `txd_start` until 1 cycle after `txd_busy` falls.
- Reset mid-frame: assert `reset` after the 2nd byte of a match frame → `txd_start` never pulses again and all outputs read 0. A fresh `test_start` afterward yields a clean 4, 3, 2, 1.

Source files
------------

// File: rtl/munch_pkg.sv
// Shared definitions for the response path of the match engine.
// Holds the serializer state encoding and the response/command byte codes,
// which the command parser reuses.
package munch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStrobe,
    StHold,
    StWait
  } sender_state_e;

  localparam logic [7:0] RESP_FOUND     = 8'h01;
  localparam logic [7:0] RESP_NOT_FOUND = 8'h00;
  localparam logic [7:0] CMD_TEST       = 8'h04;

endpackage

// File: rtl/tx_result_sender_if.sv
// Byte handshake between the result sender and async_transmitter.
//   txd_start : one-cycle strobe, sender -> transmitter
//   txd_data  : byte to send, valid with txd_start (0x00 otherwise)
//   txd_busy  : transmitter busy, transmitter -> sender
interface tx_result_sender_if;
  logic       txd_start;
  logic [7:0] txd_data;
  logic       txd_busy;

  modport master (output txd_start, output txd_data, input txd_busy);
  modport slave  (input txd_start, input txd_data, output txd_busy);
endinterface

// File: rtl/tx_result_sender.sv
// Response serializer: captures a match report or a loopback test request and
// emits it byte by byte to async_transmitter.
//   clk           : system clock
//   reset         : synchronous, active-high
//   report_start  : one-cycle match-report request (found/pos/len captured with it)
//   report_found  : match flag
//   report_pos    : 32-bit byte offset of the match, sent big-endian
//   report_len    : match length
//   test_start    : one-cycle request for the TEST_COUNT..1 test frame
//   sender_busy   : high from accept until the last byte's handshake completes
//   tx            : txd_start/txd_data/txd_busy handshake (master side)
module tx_result_sender
  import munch_pkg::*;
#(
  parameter int unsigned TEST_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      report_start,
  input  logic                      report_found,
  input  logic [31:0]               report_pos,
  input  logic [7:0]                report_len,
  input  logic                      test_start,
  output logic                      sender_busy,
  tx_result_sender_if.master        tx
);

  sender_state_e state;
  logic [47:0]   shreg;     // outgoing match frame, current byte in [47:40]
  logic [2:0]    byte_idx;  // index of the byte currently on the wire
  logic [2:0]    last_idx;  // 5 for a found frame, 0 for a not-found frame
  logic [7:0]    test_cnt;  // test frame byte value, counts down to 1
  logic          is_test;

  logic       more;
  logic [7:0] cur_byte;
  logic [7:0] next_byte;

  always_comb begin
    more      = is_test ? (test_cnt != 8'd1) : (byte_idx != last_idx);
    cur_byte  = is_test ? test_cnt : shreg[47:40];
    next_byte = is_test ? (test_cnt - 8'd1) : shreg[39:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      shreg        <= '0;
      byte_idx     <= '0;
      last_idx     <= '0;
      test_cnt     <= '0;
      is_test      <= 1'b0;
      sender_busy  <= 1'b0;
      tx.txd_start <= 1'b0;
      tx.txd_data  <= 8'h00;
    end else begin
      case (state)
        StIdle: begin
          // report_start has priority; a coincident test_start is dropped
          if (report_start) begin
            shreg       <= report_found ? {RESP_FOUND, report_pos, report_len}
                                        : {RESP_NOT_FOUND, 40'h0};
            last_idx    <= report_found ? 3'd5 : 3'd0;
            byte_idx    <= 3'd0;
            is_test     <= 1'b0;
            sender_busy <= 1'b1;
            state       <= StLoad;
          end else if (test_start) begin
            test_cnt    <= 8'(TEST_COUNT);
            is_test     <= 1'b1;
            sender_busy <= 1'b1;
            state       <= StLoad;
          end
        end
        StLoad: begin
          if (!tx.txd_busy) begin
            tx.txd_start <= 1'b1;
            tx.txd_data  <= cur_byte;
            state        <= StStrobe;
          end
        end
        StStrobe: begin
          tx.txd_start <= 1'b0;
          tx.txd_data  <= 8'h00;
          state        <= StHold;
        end
        // txd_busy rises one cycle after the strobe; skip that stale sample
        StHold: state <= StWait;
        StWait: begin
          if (!tx.txd_busy) begin
            if (more) begin
              if (is_test) begin
                test_cnt <= test_cnt - 8'd1;
              end else begin
                shreg    <= {shreg[39:0], 8'h00};
                byte_idx <= byte_idx + 3'd1;
              end
              tx.txd_start <= 1'b1;
              tx.txd_data  <= next_byte;
              state        <= StStrobe;
            end else begin
              sender_busy <= 1'b0;
              state       <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_result_sender.sv
// Self-checking bench for tx_result_sender: a frame/timing reference model is
// compared against the DUT every cycle; directed scenarios pin exact byte
// sequences, then randomized requests exercise the model.
module tb_tx_result_sender;
  localparam int unsigned TC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        report_start, report_found, test_start;
  logic [31:0] report_pos;
  logic [7:0]  report_len;
  logic        sender_busy;

  tx_result_sender_if bus ();

  tx_result_sender #(.TEST_COUNT(TC)) dut (
    .clk          (clk),
    .reset        (reset),
    .report_start (report_start),
    .report_found (report_found),
    .report_pos   (report_pos),
    .report_len   (report_len),
    .test_start   (test_start),
    .sender_busy  (sender_busy),
    .tx           (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transmitter stand-in: busy rises one cycle after it sees a strobe.
  logic tx_busy_r = 1'b0;
  logic force_busy = 1'b0;
  logic tx_pend = 1'b0;
  int   tx_cnt = 0;
  assign bus.txd_busy = tx_busy_r | force_busy;

  always @(negedge clk) begin
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_busy_r = 1'b0;
    end
    if (tx_pend) begin
      tx_pend   = 1'b0;
      tx_busy_r = 1'b1;
      tx_cnt    = $urandom_range(1, 10);
    end
    if (bus.txd_start === 1'b1) tx_pend = 1'b1;
  end

  // Reference model: a request accepted while idle queues its whole frame.
  // A byte goes out on the first edge the transmitter looks idle, but no
  // sooner than the third edge after the previous byte; once the queue is
  // empty the same rule marks the end of the frame.
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  bit         m_busy = 1'b0;
  int         gap = 0;
  logic       exp_start;
  logic [7:0] exp_data;

  always @(posedge clk) begin
    exp_start = 1'b0;
    exp_data  = 8'h00;
    if (reset) begin
      exp_q.delete();
      m_busy = 1'b0;
      gap    = 0;
    end else if (!m_busy) begin
      if (report_start) begin
        m_busy = 1'b1;
        gap    = 0;
        if (report_found) begin
          exp_q.push_back(8'h01);
          for (int b = 3; b >= 0; b--) exp_q.push_back(report_pos[b*8 +: 8]);
          exp_q.push_back(report_len);
        end else begin
          exp_q.push_back(8'h00);
        end
      end else if (test_start) begin
        m_busy = 1'b1;
        gap    = 0;
        for (int v = TC; v >= 1; v--) exp_q.push_back(8'(v));
      end
    end else if (gap > 0) begin
      gap--;
    end else if (!bus.txd_busy) begin
      if (exp_q.size() > 0) begin
        exp_start = 1'b1;
        exp_data  = exp_q.pop_front();
        gap       = 2;
      end else begin
        m_busy = 1'b0;
      end
    end
    #1;
    chk("txd_start", {31'h0, bus.txd_start}, {31'h0, exp_start});
    chk("txd_data", {24'h0, bus.txd_data}, {24'h0, exp_data});
    chk("sender_busy", {31'h0, sender_busy}, {31'h0, m_busy});
    if (bus.txd_start === 1'b1) log_q.push_back(bus.txd_data);
  end

  task automatic pulse_report(input logic found, input logic [31:0] pos, input logic [7:0] len,
                              input logic also_test);
    report_start = 1'b1;
    report_found = found;
    report_pos   = pos;
    report_len   = len;
    test_start   = also_test;
    @(negedge clk);
    report_start = 1'b0;
    test_start   = 1'b0;
    report_found = $urandom_range(0, 1);
    report_pos   = $urandom;
    report_len   = 8'($urandom);
  endtask

  task automatic pulse_test();
    test_start = 1'b1;
    @(negedge clk);
    test_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound && sender_busy !== 1'b0; i++) @(negedge clk);
    chk("idle_timeout", {31'h0, sender_busy}, 32'h0);
  endtask

  task automatic wait_log(input int n, input int bound);
    int i;
    for (i = 0; i < bound && log_q.size() < n; i++) @(negedge clk);
    chk("byte_timeout", 32'(log_q.size() >= n), 32'h1);
  endtask

  task automatic check_log(input string name, input logic [7:0] exp []);
    chk({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk(name, {24'h0, log_q[i]}, {24'h0, exp[i]});
  endtask

  logic [7:0] f_match []   = '{8'h01, 8'h00, 8'h01, 8'h27, 8'hD3, 8'h09};
  logic [7:0] f_nomatch [] = '{8'h00};
  logic [7:0] f_test []    = '{8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] f_coll []    = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h03};
  logic [7:0] f_mid []     = '{8'h01, 8'h00};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset        = 1'b1;
    report_start = 1'b0;
    report_found = 1'b0;
    report_pos   = '0;
    report_len   = '0;
    test_start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd_start", {31'h0, bus.txd_start}, 32'h0);
    chk("reset_txd_data", {24'h0, bus.txd_data}, 32'h0);
    chk("reset_busy", {31'h0, sender_busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Match report
    log_q.delete();
    pulse_report(1'b1, 32'h0001_27D3, 8'd9, 1'b0);
    wait_idle(2000);
    check_log("match_frame", f_match);

    // No match: position and length ignored
    log_q.delete();
    pulse_report(1'b0, 32'hFFFF_FFFF, 8'hAA, 1'b0);
    wait_idle(2000);
    check_log("nomatch_frame", f_nomatch);

    // Test frame
    log_q.delete();
    pulse_test();
    wait_idle(2000);
    check_log("test_frame", f_test);

    // Collision plus a mid-frame test_start
    log_q.delete();
    pulse_report(1'b1, 32'h0000_0010, 8'd3, 1'b1);
    wait_log(2, 2000);
    pulse_test();
    wait_idle(2000);
    repeat (20) @(negedge clk);
    check_log("collision_frame", f_coll);

    // Backpressure: busy held before and after the request
    while (tx_busy_r) @(negedge clk);
    log_q.delete();
    force_busy = 1'b1;
    repeat (10) @(negedge clk);
    pulse_report(1'b0, 32'h0, 8'h0, 1'b0);
    repeat (39) @(negedge clk);
    chk("bp_no_strobe", 32'(log_q.size()), 32'h0);
    force_busy = 1'b0;
    chk("bp_release_start", {31'h0, bus.txd_start}, 32'h0);
    @(negedge clk);
    chk("bp_first_start", {31'h0, bus.txd_start}, 32'h1);
    chk("bp_first_data", {24'h0, bus.txd_data}, 32'h0);
    wait_idle(2000);

    // Reset after the second byte of a match frame
    log_q.delete();
    pulse_report(1'b1, 32'h0001_27D3, 8'd9, 1'b0);
    wait_log(2, 2000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_start", {31'h0, bus.txd_start}, 32'h0);
    chk("rst_mid_data", {24'h0, bus.txd_data}, 32'h0);
    chk("rst_mid_busy", {31'h0, sender_busy}, 32'h0);
    repeat (100) @(negedge clk);
    check_log("rst_mid_frame", f_mid);
    log_q.delete();
    pulse_test();
    wait_idle(2000);
    check_log("post_reset_test", f_test);

    // Randomized requests, some overlapping an active frame
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) pulse_test();
      else pulse_report(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                        1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        if ($urandom_range(0, 1) == 0) pulse_test();
        else pulse_report(1'b1, $urandom, 8'($urandom), 1'b0);
      end
      wait_idle(3000);
    end

    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
